// File: rtl/usb_report_fifo.sv
// rtl/usb_report_fifo.sv - single-clock report FIFO with overflow policy, flush and saturating loss counter
module usb_report_fifo #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 8,
  parameter bit DROP_OLDEST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [DATA_W-1:0]            usb_data_i,
  input  logic                         usb_data_valid_i,
  output logic [DATA_W-1:0]            usb_data_o,
  output logic                         usb_data_valid_o,
  input  logic                         usb_data_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         full_o,
  output logic [15:0]                  overflow_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [15:0]       ovf_cnt;

  logic push;
  logic pop;
  logic overflow;
  logic wr_en;
  logic rd_adv;

  // When full the pointers coincide, so a drop-oldest write at wr_ptr replaces the head entry.
  always_comb begin
    push     = usb_data_valid_i & ~flush_i;
    pop      = usb_data_valid_o & usb_data_ready_i & ~flush_i;
    overflow = push & full_o & ~pop;
    wr_en    = push & (~overflow | DROP_OLDEST);
    rd_adv   = pop | (overflow & DROP_OLDEST);
  end

  assign usb_data_valid_o = (level != '0);
  assign full_o           = (level == LW'(DEPTH));
  assign level_o          = level;
  assign overflow_cnt_o   = ovf_cnt;
  assign usb_data_o       = usb_data_valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= usb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop && !full_o) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (overflow && ovf_cnt != 16'hFFFF) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule
